// File: rtl/ex_arith_unit_pkg.sv
// ex_arith_unit_pkg: shared widths, R-type function codes and divider state encoding
package ex_arith_unit_pkg;

    localparam int DATA        = 32;
    localparam int DOUBLE_DATA = 64;
    localparam int FUNCT       = 6;

    localparam logic [FUNCT-1:0] FUNCT_MFHI = 6'h10;
    localparam logic [FUNCT-1:0] FUNCT_MTHI = 6'h11;
    localparam logic [FUNCT-1:0] FUNCT_MFLO = 6'h12;
    localparam logic [FUNCT-1:0] FUNCT_MTLO = 6'h13;
    localparam logic [FUNCT-1:0] FUNCT_MULT = 6'h18;
    localparam logic [FUNCT-1:0] FUNCT_DIV  = 6'h1A;
    localparam logic [FUNCT-1:0] FUNCT_DIVU = 6'h1B;
    localparam logic [FUNCT-1:0] FUNCT_ADD  = 6'h20;
    localparam logic [FUNCT-1:0] FUNCT_ADDU = 6'h21;
    localparam logic [FUNCT-1:0] FUNCT_SUB  = 6'h22;
    localparam logic [FUNCT-1:0] FUNCT_SUBU = 6'h23;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_arith_unit_div_seq.sv
// ex_arith_unit_div_seq: 32-iteration restoring divider, signed or unsigned, result {remainder, quotient}
module ex_arith_unit_div_seq
    import ex_arith_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   div_en,
    input  logic                   signed_en,
    input  logic [DATA-1:0]        dividend,
    input  logic [DATA-1:0]        divisor,
    output logic                   done,
    output logic [DOUBLE_DATA-1:0] result
);

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [DATA-1:0] op1_q, op1_d;
    logic [DATA-1:0] op2_q, op2_d;
    logic            sgn_q, sgn_d;
    logic [DATA-1:0] rem_q, rem_d;
    logic [DATA-1:0] quo_q, quo_d;

    logic [DATA-1:0] dvs_mag;
    logic [DATA:0]   partial;
    logic [DATA:0]   diff;
    logic [DATA-1:0] quo_out;
    logic [DATA-1:0] rem_out;

    // Magnitude datapath: one shift-subtract step on the latched operands
    always_comb begin
        dvs_mag = (sgn_q && op2_q[DATA-1]) ? -op2_q : op2_q;
        partial = {rem_q, quo_q[DATA-1]};
        diff    = partial - {1'b0, dvs_mag};
        quo_out = (sgn_q && (op1_q[DATA-1] ^ op2_q[DATA-1])) ? -quo_q : quo_q;
        rem_out = (sgn_q && op1_q[DATA-1]) ? -rem_q : rem_q;
        result  = (op2_q == '0) ? {op1_q, {DATA{1'b1}}} : {rem_out, quo_out};
        done    = (state_q == DIV_DONE);
    end

    // Next-state logic: latch on start, iterate while enabled, abort on flush, single-cycle done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (div_en) begin
                    state_d = DIV_BUSY;
                    cnt_d   = '0;
                    op1_d   = dividend;
                    op2_d   = divisor;
                    sgn_d   = signed_en;
                    rem_d   = '0;
                    quo_d   = (signed_en && dividend[DATA-1]) ? -dividend : dividend;
                end
            end
            DIV_BUSY: begin
                if (!div_en) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d   = diff[DATA] ? partial[DATA-1:0] : diff[DATA-1:0];
                    quo_d   = {quo_q[DATA-2:0], ~diff[DATA]};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd31) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Divider state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

endmodule

// File: rtl/ex_arith_unit.sv
// ex_arith_unit: execute-stage add/sub, sequential divide, HI/LO access and stall request
module ex_arith_unit
    import ex_arith_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FUNCT-1:0]       funct,
    input  logic [DATA-1:0]        operand_1,
    input  logic [DATA-1:0]        operand_2,
    input  logic                   reg_write_en_in,
    input  logic [DATA-1:0]        hi_read_data,
    input  logic [DATA-1:0]        lo_read_data,
    input  logic                   mult_done,
    input  logic [DOUBLE_DATA-1:0] mult_result,
    output logic [DATA-1:0]        result,
    output logic                   reg_write_en_out,
    output logic                   overflow_flag,
    output logic [DATA-1:0]        hi_write_data,
    output logic [DATA-1:0]        lo_write_data,
    output logic                   hilo_write_en,
    output logic                   stall_request
);

    logic                   add_en;
    logic                   sub_op;
    logic                   trap_op;
    logic                   mul_en;
    logic                   div_en;
    logic                   signed_en;
    logic                   div_done;
    logic                   mult_div_done;
    logic [DATA-1:0]        addend;
    logic [DATA-1:0]        sum;
    logic [DATA-1:0]        hilo_result;
    logic [DOUBLE_DATA-1:0] div_result;

    // Function decode
    always_comb begin
        add_en    = (funct == FUNCT_ADD) || (funct == FUNCT_ADDU) ||
                    (funct == FUNCT_SUB) || (funct == FUNCT_SUBU);
        sub_op    = (funct == FUNCT_SUB) || (funct == FUNCT_SUBU);
        trap_op   = (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
        mul_en    = (funct == FUNCT_MULT);
        div_en    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
        signed_en = (funct == FUNCT_DIV);
    end

    // Subtraction is op1 + ~op2 + 1; overflow compares op1 against the inverted operand
    always_comb begin
        addend           = sub_op ? ~operand_2 : operand_2;
        sum              = operand_1 + addend + {{(DATA-1){1'b0}}, sub_op};
        overflow_flag    = trap_op && (operand_1[DATA-1] == addend[DATA-1]) &&
                           (sum[DATA-1] != operand_1[DATA-1]);
        reg_write_en_out = reg_write_en_in & ~overflow_flag;
    end

    ex_arith_unit_div_seq u_div (
        .clk       (clk),
        .rst       (rst),
        .div_en    (div_en),
        .signed_en (signed_en),
        .dividend  (operand_1),
        .divisor   (operand_2),
        .done      (div_done),
        .result    (div_result)
    );

    // Completion and stall while a multiply or divide is outstanding
    always_comb begin
        mult_div_done = (mul_en & mult_done) | (div_en & div_done);
        stall_request = (mul_en | div_en) & ~mult_div_done;
    end

    // HI/LO write generator: mul/div commit wins over MTHI/MTLO
    always_comb begin
        hi_write_data = '0;
        lo_write_data = '0;
        hilo_write_en = 1'b0;
        if (mult_div_done) begin
            {hi_write_data, lo_write_data} = mul_en ? mult_result : div_result;
            hilo_write_en                  = 1'b1;
        end else if (funct == FUNCT_MTHI) begin
            hi_write_data = operand_1;
            lo_write_data = lo_read_data;
            hilo_write_en = 1'b1;
        end else if (funct == FUNCT_MTLO) begin
            hi_write_data = hi_read_data;
            lo_write_data = operand_1;
            hilo_write_en = 1'b1;
        end
    end

    // Result mux: adder for add/sub, HI/LO read for MFHI/MFLO, zero otherwise
    always_comb begin
        hilo_result = (funct == FUNCT_MFHI) ? hi_read_data :
                      (funct == FUNCT_MFLO) ? lo_read_data : '0;
        result      = add_en ? sum : hilo_result;
    end

endmodule

// File: tb/tb_ex_arith_unit.sv
// tb_ex_arith_unit: directed self-checking bench for ex_arith_unit
module tb_ex_arith_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic [31:0] operand_1, operand_2;
    logic        reg_write_en_in;
    logic [31:0] hi_read_data, lo_read_data;
    logic        mult_done;
    logic [63:0] mult_result;
    logic [31:0] result;
    logic        reg_write_en_out, overflow_flag;
    logic [31:0] hi_write_data, lo_write_data;
    logic        hilo_write_en, stall_request;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_arith_unit dut (
        .clk              (clk),
        .rst              (rst),
        .funct            (funct),
        .operand_1        (operand_1),
        .operand_2        (operand_2),
        .reg_write_en_in  (reg_write_en_in),
        .hi_read_data     (hi_read_data),
        .lo_read_data     (lo_read_data),
        .mult_done        (mult_done),
        .mult_result      (mult_result),
        .result           (result),
        .reg_write_en_out (reg_write_en_out),
        .overflow_flag    (overflow_flag),
        .hi_write_data    (hi_write_data),
        .lo_write_data    (lo_write_data),
        .hilo_write_en    (hilo_write_en),
        .stall_request    (stall_request)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; funct = 6'h1A; operand_1 = 32'd9; operand_2 = 32'd3;
        reg_write_en_in = 1'b1; hi_read_data = '0; lo_read_data = '0;
        mult_done = 1'b0; mult_result = '0;
        step(); step();
        @(negedge clk);
        checks++; if (hilo_write_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", hilo_write_en); end
        checks++; if (stall_request !== 1'b1) begin failures++; $display("FAIL reset_stall_div: got %b want 1", stall_request); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
        step();
        funct = 6'h00;
        #1 rst = 1'b1;
        step();
        @(negedge clk);
        checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL reset_stall_idle: got %b want 0", stall_request); end
        step();
    endtask

    task automatic test_adder();
        logic [5:0]  fv [9] = '{6'h20, 6'h21, 6'h22, 6'h22, 6'h23, 6'h20, 6'h20, 6'h22, 6'h24};
        logic [31:0] av [9] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h80000000,
                                32'hFFFFFFFF, 32'h80000000, 32'h0, 32'd5};
        logic [31:0] bv [9] = '{32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                                32'h80000000, 32'd3};
        logic [31:0] rv [9] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                32'hFFFFFFFE, 32'h0, 32'h80000000, 32'h0};
        logic        ov [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            funct = fv[i]; operand_1 = av[i]; operand_2 = bv[i]; reg_write_en_in = 1'b1;
            @(negedge clk);
            checks++; if (result !== rv[i]) begin failures++; $display("FAIL adder_result[%0d]: got %h want %h", i, result, rv[i]); end
            checks++; if (overflow_flag !== ov[i]) begin failures++; $display("FAIL adder_ovf[%0d]: got %b want %b", i, overflow_flag, ov[i]); end
            checks++; if (reg_write_en_out !== !ov[i]) begin failures++; $display("FAIL adder_rwe[%0d]: got %b want %b", i, reg_write_en_out, !ov[i]); end
            checks++; if (hilo_write_en !== 1'b0 || stall_request !== 1'b0) begin failures++; $display("FAIL adder_en_stall[%0d]: got %b%b want 00", i, hilo_write_en, stall_request); end
            step();
        end
        funct = 6'h21; reg_write_en_in = 1'b0;
        @(negedge clk);
        checks++; if (reg_write_en_out !== 1'b0) begin failures++; $display("FAIL adder_rwe_in0: got %b want 0", reg_write_en_out); end
        step();
        reg_write_en_in = 1'b1;
    endtask

    task automatic test_hilo();
        funct = 6'h11; operand_1 = 32'h1234; hi_read_data = 32'h99; lo_read_data = 32'hAA;
        @(negedge clk);
        checks++; if ({hilo_write_en, hi_write_data, lo_write_data} !== {1'b1, 32'h1234, 32'hAA}) begin failures++; $display("FAIL mthi: got %b %h %h want 1 00001234 000000aa", hilo_write_en, hi_write_data, lo_write_data); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL mthi_result: got %h want 0", result); end
        step();
        funct = 6'h13; operand_1 = 32'h5678;
        @(negedge clk);
        checks++; if ({hilo_write_en, hi_write_data, lo_write_data} !== {1'b1, 32'h99, 32'h5678}) begin failures++; $display("FAIL mtlo: got %b %h %h want 1 00000099 00005678", hilo_write_en, hi_write_data, lo_write_data); end
        step();
        funct = 6'h12; lo_read_data = 32'h55;
        @(negedge clk);
        checks++; if (result !== 32'h55 || hilo_write_en !== 1'b0) begin failures++; $display("FAIL mflo: got %h en %b want 00000055 en 0", result, hilo_write_en); end
        step();
        funct = 6'h10;
        @(negedge clk);
        checks++; if (result !== 32'h99 || hilo_write_en !== 1'b0) begin failures++; $display("FAIL mfhi: got %h en %b want 00000099 en 0", result, hilo_write_en); end
        step();
    endtask

    task automatic test_mult();
        funct = 6'h18; mult_done = 1'b0; mult_result = 64'h1_00000002;
        @(negedge clk);
        checks++; if (stall_request !== 1'b1 || hilo_write_en !== 1'b0) begin failures++; $display("FAIL mult_wait: got stall %b en %b want 1 0", stall_request, hilo_write_en); end
        step();
        mult_done = 1'b1;
        @(negedge clk);
        checks++; if (stall_request !== 1'b0) begin failures++; $display("FAIL mult_stall: got %b want 0", stall_request); end
        checks++; if ({hilo_write_en, hi_write_data, lo_write_data} !== {1'b1, 32'h1, 32'h2}) begin failures++; $display("FAIL mult_commit: got %b %h %h want 1 00000001 00000002", hilo_write_en, hi_write_data, lo_write_data); end
        step();
        funct = 6'h21;
        @(negedge clk);
        checks++; if (hilo_write_en !== 1'b0) begin failures++; $display("FAIL mult_done_no_mul: got %b want 0", hilo_write_en); end
        step();
        mult_done = 1'b0;
    endtask

    task automatic test_div();
        funct = 6'h1A; operand_1 = 32'hFFFFFFF9; operand_2 = 32'd2;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            checks++; if (stall_request !== (c < 33)) begin failures++; $display("FAIL div_stall[%0d]: got %b want %b", c, stall_request, c < 33); end
            checks++; if (hilo_write_en !== (c == 33)) begin failures++; $display("FAIL div_en[%0d]: got %b want %b", c, hilo_write_en, c == 33); end
            if (c == 33) begin
                checks++; if ({hi_write_data, lo_write_data} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin failures++; $display("FAIL div_value: got %h %h want ffffffff fffffffd", hi_write_data, lo_write_data); end
            end
            step();
        end
        funct = 6'h00;
        step();
    endtask

    task automatic test_div_corner();
        logic [5:0]  fv [7] = '{6'h1B, 6'h1A, 6'h1A, 6'h1B, 6'h1A, 6'h1A, 6'h1B};
        logic [31:0] av [7] = '{32'd7, 32'hFFFFFFFB, 32'h80000000, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9, 32'd100};
        logic [31:0] bv [7] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd16, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7};
        logic [31:0] hv [7] = '{32'd7, 32'hFFFFFFFB, 32'd0, 32'd15, 32'd1, 32'hFFFFFFFF, 32'd2};
        logic [31:0] lv [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0FFFFFFF, 32'hFFFFFFFD, 32'd3, 32'd14};
        for (int i = 0; i < 7; i++) begin
            int lat = -1;
            logic [31:0] hh = '0, ll = '0;
            funct = fv[i]; operand_1 = av[i]; operand_2 = bv[i];
            for (int c = 0; c < 40 && lat < 0; c++) begin
                @(negedge clk);
                if (hilo_write_en) begin lat = c; hh = hi_write_data; ll = lo_write_data; end
                else step();
            end
            funct = 6'h00;
            checks++; if (lat != 33) begin failures++; $display("FAIL divc_latency[%0d]: got %0d want 33", i, lat); end
            checks++; if ({hh, ll} !== {hv[i], lv[i]}) begin failures++; $display("FAIL divc_value[%0d]: got %h %h want %h %h", i, hh, ll, hv[i], lv[i]); end
            step();
        end
    endtask

    task automatic test_operand_hold();
        int lat = -1;
        logic [31:0] hh = '0, ll = '0;
        funct = 6'h1B; operand_1 = 32'd100; operand_2 = 32'd7;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            if (c == 5) begin operand_1 = 32'd9; operand_2 = 32'd3; end
            @(negedge clk);
            if (hilo_write_en) begin lat = c; hh = hi_write_data; ll = lo_write_data; end
            else step();
        end
        funct = 6'h00;
        checks++; if (lat != 33) begin failures++; $display("FAIL hold_latency: got %0d want 33", lat); end
        checks++; if ({hh, ll} !== {32'd2, 32'd14}) begin failures++; $display("FAIL hold_value: got %h %h want 00000002 0000000e", hh, ll); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        logic [31:0] hh = '0, ll = '0;
        funct = 6'h1B; operand_1 = 32'd7; operand_2 = 32'd2;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (hilo_write_en) begin lat = c; hh = hi_write_data; ll = lo_write_data; end
            else step();
        end
        checks++; if (lat != 33 || {hh, ll} !== {32'd1, 32'd3}) begin failures++; $display("FAIL b2b_first: got lat %0d %h %h want 33 00000001 00000003", lat, hh, ll); end
        step();
        operand_1 = 32'd9; operand_2 = 32'd4;
        @(negedge clk);
        checks++; if (stall_request !== 1'b1 || hilo_write_en !== 1'b0) begin failures++; $display("FAIL b2b_restart: got stall %b en %b want 1 0", stall_request, hilo_write_en); end
        lat = -1;
        for (int c = 34; c < 80 && lat < 0; c++) begin
            if (c > 34) @(negedge clk);
            if (hilo_write_en) begin lat = c; hh = hi_write_data; ll = lo_write_data; end
            else step();
        end
        funct = 6'h00;
        checks++; if (lat != 67 || {hh, ll} !== {32'd1, 32'd2}) begin failures++; $display("FAIL b2b_second: got lat %0d %h %h want 67 00000001 00000002", lat, hh, ll); end
        step();
    endtask

    task automatic test_flush();
        int hits = 0;
        funct = 6'h1B; operand_1 = 32'd20; operand_2 = 32'd3;
        repeat (5) step();
        funct = 6'h21; operand_1 = 32'd1; operand_2 = 32'd2;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (hilo_write_en || stall_request) hits++;
            step();
        end
        checks++; if (hits != 0) begin failures++; $display("FAIL flush_no_done: got %0d active cycles want 0", hits); end
        @(negedge clk);
        checks++; if (result !== 32'd3) begin failures++; $display("FAIL flush_addu: got %h want 00000003", result); end
        step();
    endtask

    task automatic test_reset_mid_div();
        int lat = -1;
        logic [31:0] hh = '0, ll = '0;
        funct = 6'h1A; operand_1 = 32'd100; operand_2 = 32'hFFFFFFF9;
        repeat (10) step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (hilo_write_en !== 1'b0 || stall_request !== 1'b1) begin failures++; $display("FAIL rstmid_state: got en %b stall %b want 0 1", hilo_write_en, stall_request); end
        step();
        rst = 1'b1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (hilo_write_en) begin lat = c; hh = hi_write_data; ll = lo_write_data; end
            else step();
        end
        funct = 6'h00;
        checks++; if (lat != 33) begin failures++; $display("FAIL rstmid_latency: got %0d want 33", lat); end
        checks++; if ({hh, ll} !== {32'd2, 32'hFFFFFFF2}) begin failures++; $display("FAIL rstmid_value: got %h %h want 00000002 fffffff2", hh, ll); end
        step();
    endtask

    initial begin
        test_reset();
        test_adder();
        test_hilo();
        test_mult();
        test_div();
        test_div_corner();
        test_operand_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_arith_unit.md
# ex_arith_unit

Execute-stage arithmetic and HI/LO block of the 5-stage MIPS core. It combines three functions:
- a combinational 32-bit add/subtract unit with signed-overflow detection;
- a multi-cycle sequential 32-bit divider;
- the HI/LO read/write generator that also commits multiply/divide results.

It sits between the ID/EX pipeline register and the MEM stage. It also drives the pipeline stall request while a divide (or external multiply) is outstanding.

## Interface
- No parameters; widths come from the shared package (DATA=32, FUNCT=6).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- funct  in  6  MIPS R-type function code from ID.
- operand_1  in  32  rs value (dividend, minuend, MTHI/MTLO source).
- operand_2  in  32  rt value (divisor, addend/subtrahend).
- reg_write_en_in  in  1  register write request from ID.
- hi_read_data, lo_read_data  in  32 each  current HI/LO contents.
- mult_done  in  1  external multiplier result valid.
- mult_result  in  64  external multiplier product {hi,lo}.
- result  out  32  ALU/HILO result to WB path.
- reg_write_en_out  out  1  reg_write_en_in & ~overflow_flag.
- overflow_flag  out  1  signed overflow on ADD/SUB.
- hi_write_data, lo_write_data  out  32 each  new HI/LO values.
- hilo_write_en  out  1  commit HI/LO this cycle.
- stall_request  out  1  hold pipeline; mul/div not yet done.

## Operation
- Decode (funct):
  - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23 → adder.
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13 → hilo.
  - MULT 0x18 → mul_en.
  - DIV 0x1A (signed), DIVU 0x1B (unsigned) → div_en.
  - Any other funct: all enables 0.
- Adder:
  - ADD/ADDU result = op1+op2; SUB/SUBU result = op1−op2, modulo 2^32.
  - overflow_flag=1 only for ADD/SUB when both operands have equal sign (for SUB: op1 vs ~op2) and the result sign differs.
  - overflow_flag=0 for ADDU/SUBU and all non-adder ops.
- Divider, signed:
  - Divide magnitudes.
  - Quotient negated if operand signs differ; remainder takes dividend sign.
  - 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divider, unsigned: plain restoring division.
- Divide by zero: quotient 0xFFFFFFFF, remainder = operand_1 (both DIV and DIVU).
- Divider output: div_result = {remainder, quotient}.
- mult_div_done = (mul_en & mult_done) | (div_en & div_done).
- stall_request = (mul_en | div_en) & ~mult_div_done.
- Hilo_gen, in priority order:
  - mult_div_done: hi/lo_write = selected 64-bit result [63:32]/[31:0], en=1.
  - MTHI: hi_write=operand_1, lo_write=lo_read_data, en=1.
  - MTLO: hi_write=hi_read_data, lo_write=operand_1, en=1.
  - MFHI: result=hi_read_data. MFLO: result=lo_read_data. en=0 for both.
  - Otherwise: en=0, hi/lo_write=0.
- Result mux: adder result for adder ops, hilo result for MFHI/MFLO, else 0.

## Timing
- Adder, hilo and mux are purely combinational; zero latency.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: on an edge with div_en=1, latch operands and signedness, counter=0, go to BUSY.
  - BUSY: one quotient bit per edge. After 32 iterations go to DONE.
  - DONE: div_done=1 and result valid for exactly one cycle. Next edge unconditionally returns to IDLE.
- Latency: with div_en first high in cycle 0, div_done is high in cycle 33. stall_request is high in cycles 0–32, low in cycle 33.
- Back-to-back DIV: div_en still high in IDLE (cycle 34) starts a new division.
- Operand changes while BUSY are ignored (operands are latched).
- div_en dropping while BUSY (flush) aborts; FSM returns to IDLE on the next edge, div_done stays 0.
- rst low at any time: FSM to IDLE, counter and latched operands 0, div_done=0 immediately. Combinational outputs then follow their inputs.

## Structure
- Shared package holds the FUNCT_* constants, DATA/DOUBLE_DATA/FUNCT widths, and the divider state encoding.
- One natural sub-module: div_seq (sequential divider with clk, rst, div_en, signed_en, operands, done, 64-bit result).
- Adder, hilo generator and result mux stay inline in ex_arith_unit.

## Test plan
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow_flag=1, reg_write_en_out=0. ADDU same operands → overflow_flag=0, reg_write_en_out=1.
- SUB 5−7 → 0xFFFFFFFE, no overflow. SUB 0x80000000−1 → overflow_flag=1.
- DIV −7/2 held stable → stall high cycles 0–32; cycle 33: hilo_write_en=1, hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIVU 7/0 → hi=7, lo=0xFFFFFFFF.
- MTHI op1=0x1234 with lo_read=0xAA → hi_write=0x1234, lo_write=0xAA, en=1. MFLO with lo_read=0x55 → result 0x55, en=0.
- MULT with mult_done pulsed, mult_result=0x1_00000002 → stall drops that cycle, hi=1, lo=2, en=1.
- rst asserted in cycle 10 of a DIV → div_done 0, FSM IDLE; after release with div_en high, done arrives 33 cycles later.
